// File: rtl/gec_pkg.sv
// Shared types and constants for the gated event counter.
package gec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_OPEN,
        COUNT,
        HOLD
    } gec_state_t;

    localparam int GEC_CNT_W      = 16;
    localparam int GEC_RUN_CYCLES = 2;
    localparam int GEC_TIMEOUT    = 1024;

    // All-ones value of a w-bit counter, w up to 64.
    function automatic logic [63:0] sat_max(input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            v[i] = (i < w);
        end
        return v;
    endfunction

endpackage

// File: rtl/gated_event_counter_sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_edge <= r_s2 & ~r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/gated_event_counter.sv
// Arms one pulse-gate window, counts event edges while done_in is low.
// Optional watchdog on the wait states: define GEC_TIMEOUT_EN.
module gated_event_counter
    import gec_pkg::*;
#(
    parameter int CNT_W      = GEC_CNT_W,
    parameter int RUN_CYCLES = GEC_RUN_CYCLES,
    parameter int TIMEOUT    = GEC_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             done_in,
    input  logic             evt_in,
    output logic             run_out,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ack,
`ifdef GEC_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             overflow
);

    localparam int ARM_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(sat_max(CNT_W));

    gec_state_t       r_state;
    gec_state_t       w_state_next;
    logic [ARM_W-1:0] r_arm_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_int;
    logic [CNT_W-1:0] r_count_out;
    logic             r_overflow;
    logic             r_count_valid;
    logic             w_edge;
    logic             w_run;
    logic             w_wd_hit;

    sync_edge_detect u_evt_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (evt_in),
        .o_edge  (w_edge)
    );

`ifdef GEC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_timeout_err;
    logic            w_wd_active;

    assign w_wd_active = (r_state == WAIT_OPEN) || (r_state == COUNT);
    assign w_wd_hit    = w_wd_active && (r_wd == WD_W'(TIMEOUT - 1));

    // Watchdog restarts whenever the state changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (!w_wd_active || (w_state_next != r_state)) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
            if ((r_state == IDLE) && start) begin
                r_timeout_err <= 1'b0;
            end else if (w_wd_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wd_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_next = ARM;
            end
            ARM: begin
                w_run = 1'b1;
                if (r_arm_cnt == ARM_W'(RUN_CYCLES - 1)) begin
                    w_state_next = WAIT_OPEN;
                end
            end
            WAIT_OPEN: begin
                if (!done_in) w_state_next = COUNT;
            end
            COUNT: begin
                if (done_in) w_state_next = HOLD;
            end
            HOLD: begin
                if (count_ack) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_wd_hit) w_state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_arm_cnt     <= '0;
            r_cnt         <= '0;
            r_ovf_int     <= 1'b0;
            r_count_out   <= '0;
            r_overflow    <= 1'b0;
            r_count_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == ARM) && (w_state_next == ARM)) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end else begin
                r_arm_cnt <= '0;
            end

            // An edge in the closing cycle (done_in high) is excluded.
            if ((r_state == IDLE) && start) begin
                r_cnt     <= '0;
                r_ovf_int <= 1'b0;
            end else if ((r_state == COUNT) && !done_in && w_edge) begin
                if (r_cnt == MAXV) begin
                    r_ovf_int <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if ((r_state == COUNT) && (w_state_next == HOLD)) begin
                r_count_out   <= r_cnt;
                r_overflow    <= r_ovf_int;
                r_count_valid <= 1'b1;
            end else if ((r_state == HOLD) && count_ack) begin
                r_count_valid <= 1'b0;
            end
        end
    end

    assign run_out     = w_run;
    assign busy        = (r_state != IDLE);
    assign count_out   = r_count_out;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_gated_event_counter.sv
// Directed bench for gated_event_counter (CNT_W=4, RUN_CYCLES=3).
module tb_gated_event_counter;

    localparam int CW = 4;
    localparam int RC = 3;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done_in;
    logic          evt_in;
    logic          count_ack;
    logic          run_out;
    logic          busy;
    logic [CW-1:0] count_out;
    logic          count_valid;
    logic          overflow;
`ifdef GEC_TIMEOUT_EN
    logic          timeout_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    gated_event_counter #(
        .CNT_W      (CW),
        .RUN_CYCLES (RC),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done_in     (done_in),
        .evt_in      (evt_in),
        .run_out     (run_out),
        .busy        (busy),
        .count_out   (count_out),
        .count_valid (count_valid),
        .count_ack   (count_ack),
`ifdef GEC_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .overflow    (overflow)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            evt_in = 1'b1;
            tick(4);
            evt_in = 1'b0;
            tick(4);
        end
    endtask

    // start -> ARM for RC cycles -> WAIT_OPEN -> open window -> COUNT
    task automatic arm_and_open();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(RC);
        done_in = 1'b0;
        tick();
    endtask

    task automatic close_window();
        done_in = 1'b1;
        tick();
    endtask

    task automatic ack();
        count_ack = 1'b1;
        tick();
        count_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        done_in   = 1'b1;
        evt_in    = 1'b0;
        count_ack = 1'b0;
        #3;
        chk("rst_run", run_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", count_valid, 0);
        chk("rst_count", count_out, 0);
        chk("rst_ovf", overflow, 0);
        tick(2);
        reset = 1'b0;
        tick();

        // run timing, second start ignored, then 7 events
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_c1", run_out, 1);
        chk("busy_c1", busy, 1);
        tick();
        chk("run_c2", run_out, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_c3", run_out, 1);
        tick();
        chk("run_c4", run_out, 0);
        chk("busy_c4", busy, 1);
        tick(2);
        chk("no_rearm", run_out, 0);
        done_in = 1'b0;
        tick();
        pulses(7);
        close_window();
        chk("basic_valid", count_valid, 1);
        chk("basic_count", count_out, 7);
        chk("basic_ovf", overflow, 0);
        ack();
        chk("ack_valid", count_valid, 0);
        chk("ack_busy", busy, 0);
        chk("ack_keep", count_out, 7);

        count_ack = 1'b1;
        tick();
        count_ack = 1'b0;
        chk("stray_ack", busy, 0);

        // edges in WAIT_OPEN and in the closing cycle are excluded
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(RC);
        pulses(1);
        done_in = 1'b0;
        tick();
        evt_in = 1'b1;
        tick(3);
        done_in = 1'b1;
        tick();
        evt_in = 1'b0;
        chk("win_valid", count_valid, 1);
        chk("win_count", count_out, 0);
        chk("win_ovf", overflow, 0);
        ack();
        tick(4);

        // saturation
        arm_and_open();
        pulses(20);
        close_window();
        chk("sat_count", count_out, 15);
        chk("sat_ovf", overflow, 1);

        // start together with ack in HOLD: ack wins, start dropped
        start     = 1'b1;
        count_ack = 1'b1;
        tick();
        start     = 1'b0;
        count_ack = 1'b0;
        chk("sa_valid", count_valid, 0);
        chk("sa_busy", busy, 0);
        tick();
        chk("sa_drop", busy, 0);

        arm_and_open();
        pulses(2);
        close_window();
        chk("two_count", count_out, 2);
        chk("two_ovf", overflow, 0);
        ack();

        // reset mid-COUNT
        arm_and_open();
        pulses(5);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_run", run_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_valid", count_valid, 0);
        chk("mr_count", count_out, 0);
        chk("mr_ovf", overflow, 0);
        #2;
        reset = 1'b0;
        tick();
        done_in = 1'b1;
        tick(5);
        chk("mr_post_valid", count_valid, 0);
        chk("mr_post_busy", busy, 0);

`ifdef GEC_TIMEOUT_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(RC);
        tick(TO - 1);
        chk("to_pre_busy", busy, 1);
        chk("to_pre_err", timeout_err, 0);
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_valid", count_valid, 0);
        chk("to_run", run_out, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_clear", timeout_err, 0);
        chk("to_rearm", run_out, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gated_event_counter.md
Name: gated_event_counter

Overview:
- Control and capture stage that sits beside the clock pulse-gate block. It drives the gate's run input and consumes the gate's done output.
- It arms one gate window and counts rising edges of an asynchronous event input while the window is open (done low).
- When done rises, it latches the count and presents it with a valid/ack handshake.
- Forms the measurement core of the counter design: the number of events per COUNT gated clocks.

Parameters:
- CNT_W, 16, width of the event counter and result.
- RUN_CYCLES, 2, number of clk cycles run_out is held high per arm (must be >= 1).
- TIMEOUT, 1024, watchdog limit in clk cycles for each wait state (used only with the optional feature).

Ports:
- clk  in  1  system clock; the same clock fed to the pulse-gate block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one measurement; sampled in IDLE only.
- done_in  in  1  done output of the pulse-gate block.
- evt_in  in  1  asynchronous event input to be counted.
- run_out  out  1  drives the pulse-gate run input.
- busy  out  1  high in every state except IDLE.
- count_out  out  CNT_W  latched event count.
- count_valid  out  1  count_out holds a new result.
- count_ack  in  1  consumer accepts the result.
- overflow  out  1  the counter saturated during this measurement; latched alongside count_out.
- timeout_err  out  1  present only with GEC_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs = 0; run_out = 0; internal counter = 0; synchroniser flops = 0.
- Event sampling:
  - evt_in passes through a 2-flop synchroniser, then a rising-edge detect register.
  - An edge is therefore flagged 3 clk cycles after evt_in rises.
- State machine, states IDLE, ARM, WAIT_OPEN, COUNT, HOLD:
  - IDLE: when start = 1, clear the counter and clear overflow, then go to ARM. count_out keeps its previous value until the next latch.
  - ARM: run_out = 1 for exactly RUN_CYCLES cycles, then run_out = 0 and go to WAIT_OPEN.
  - WAIT_OPEN: when done_in = 0, go to COUNT. Edges seen in WAIT_OPEN are not counted.
  - COUNT: in each cycle with done_in = 0 and an edge flagged, counter += 1.
    - Saturate at 2^CNT_W - 1; the first increment attempted at that value sets the internal overflow flag.
    - When done_in = 1, go to HOLD. An edge flagged in that same cycle is not counted.
  - Transition COUNT to HOLD: count_out <= counter, overflow <= internal overflow flag, count_valid <= 1, all registered.
  - HOLD: stay until count_ack = 1, then count_valid <= 0 on the next edge and go to IDLE.
- Timing and latency:
  - start high at cycle 0 puts run_out high during cycles 1 .. RUN_CYCLES.
  - count_valid rises 1 cycle after done_in is sampled high in COUNT.
- Boundary rules:
  - start outside IDLE is ignored; it is not queued.
  - count_ack while count_valid = 0 is ignored.
  - start and count_ack in the same cycle while in HOLD: ack is taken, start is dropped.
  - Reset mid-measurement: immediate return to IDLE; run_out = 0; result is discarded.
  - Zero events in the window: count_out = 0, count_valid = 1, overflow = 0.

Optional Feature:
- Macro GEC_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in WAIT_OPEN and COUNT and restarts on each state entry.
  - Reaching TIMEOUT cycles forces IDLE with run_out = 0 and count_valid = 0, and sets timeout_err.
  - timeout_err is sticky until the next accepted start or reset.
- When undefined:
  - No watchdog logic, no timeout_err port, and TIMEOUT is unused.
  - The FSM waits indefinitely in WAIT_OPEN and COUNT.

Decomposition:
- Shared package gec_pkg holds:
  - the state enum (IDLE, ARM, WAIT_OPEN, COUNT, HOLD);
  - the default CNT_W and RUN_CYCLES constants;
  - the saturating max-value constant helper.
- One sub-module, sync_edge_detect: the 2-flop synchroniser plus rising-edge pulse, with async active-high reset. It is reusable for other asynchronous inputs in the counter design.

Test Plan:
- Basic count: reset; start; model the gate with done_in low for 100 cycles; 7 evt_in pulses, each 4 cycles wide with 4 cycles apart, inside the window. Expect count_out = 7, count_valid = 1, overflow = 0; ack clears valid in 1 cycle and busy = 0.
- Run timing: RUN_CYCLES = 3; start at cycle 0. Expect run_out high during cycles 1-3 only; a second start in cycle 2 is ignored (busy stays 1, no second arm).
- Saturation: CNT_W = 4; 20 edges in the window. Expect count_out = 15, overflow = 1. A next measurement with 2 edges gives count_out = 2, overflow = 0.
- Window edges: an edge flagged in the cycle done_in rises is not counted; edges flagged in WAIT_OPEN are not counted. Expect 0 for a window containing only such edges.
- Reset mid-COUNT: assert reset after 5 counted edges. Expect all outputs 0 asynchronously, state IDLE, and no count_valid after release.
- GEC_TIMEOUT_EN: TIMEOUT = 50, done_in held high after arm. Expect timeout_err = 1 at cycle 50 of WAIT_OPEN, IDLE state, and count_valid = 0; the next start clears timeout_err.
